onebysixteen_demux_loader: RTL and testbench

Write-side counterpart of the 16:1 output mux. Accepts a stream of SIZE-bit words on a valid/ready handshake and distributes them into 16 holding registers y0..y15, which the read-side mux then selects by OutMuxAdd. Two modes:
- Addressed: the target slot comes from InMuxAdd.
- Auto-increment: the target slot comes from an internal write pointer.
Tracks which slots hold valid data and reports when the bank is complete.

---
 rtl/onebysixteen_demux_loader.sv | 161 ++++++++++++++++
 tb/tb_onebysixteen_demux_loader.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/onebysixteen_demux_loader.sv
// onebysixteen_demux_loader
//   Write-side companion to the 16:1 output mux. It accepts SIZE-bit words on
//   a valid/ready handshake and steers each word into one of 16 holding
//   registers (y0..y15). The target slot comes from InMuxAdd in addressed mode
//   or from an internal write pointer in auto-increment mode. A valid mask
//   tracks which slots have been written. The block raises full, and pulses
//   done once, when the bank becomes complete.
//
// Ports
//   clk, rst         clock; synchronous active-high reset
//   din/din_valid    write word and its valid strobe
//   din_ready        combinational; a word is accepted this cycle
//   InMuxAdd         target slot in addressed mode
//   auto_inc         1 = take the slot from wr_ptr and advance the pointer
//   clear            clears the pointer, valid mask and state; slot data is kept
//   y0..y15          registered holding slots
//   valid_mask       per-slot written flags
//   wr_ptr           auto-increment pointer
//   full / done      bank complete / one-cycle completion pulse

// One holding slot. Reset zeroes the data. clear does not touch it.
module onebysixteen_demux_loader_slot #(
  parameter int SIZE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_we,
  input  logic [SIZE-1:0] i_d,
  output logic [SIZE-1:0] o_q
);
  logic [SIZE-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst)       r_q <= '0;
    else if (i_we) r_q <= i_d;
  end

  assign o_q = r_q;
endmodule

module onebysixteen_demux_loader #(
  parameter int SIZE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SIZE-1:0] din,
  input  logic            din_valid,
  output logic            din_ready,
  input  logic [3:0]      InMuxAdd,
  input  logic            auto_inc,
  input  logic            clear,
  output logic [SIZE-1:0] y0,
  output logic [SIZE-1:0] y1,
  output logic [SIZE-1:0] y2,
  output logic [SIZE-1:0] y3,
  output logic [SIZE-1:0] y4,
  output logic [SIZE-1:0] y5,
  output logic [SIZE-1:0] y6,
  output logic [SIZE-1:0] y7,
  output logic [SIZE-1:0] y8,
  output logic [SIZE-1:0] y9,
  output logic [SIZE-1:0] y10,
  output logic [SIZE-1:0] y11,
  output logic [SIZE-1:0] y12,
  output logic [SIZE-1:0] y13,
  output logic [SIZE-1:0] y14,
  output logic [SIZE-1:0] y15,
  output logic [15:0]     valid_mask,
  output logic [3:0]      wr_ptr,
  output logic            full,
  output logic            done
);
  localparam int NUM_SLOTS = 16;

  typedef enum logic [1:0] {
    S_EMPTY   = 2'd0,
    S_FILLING = 2'd1,
    S_FULL    = 2'd2
  } state_t;

  state_t                          r_state;
  logic [NUM_SLOTS-1:0]            r_valid_mask;
  logic [3:0]                      r_wr_ptr;
  logic                            r_full;
  logic                            r_done;

  logic                            w_xfer;
  logic [3:0]                      w_slot;
  logic [NUM_SLOTS-1:0]            w_slot_oh;
  logic [NUM_SLOTS-1:0]            w_we;
  logic [NUM_SLOTS-1:0]            w_mask_nxt;
  logic [NUM_SLOTS-1:0][SIZE-1:0]  w_y;

  // clear blocks acceptance in its own cycle, so a simultaneous word is dropped.
  assign din_ready  = (r_state != S_FULL) & ~clear;
  assign w_xfer     = din_valid & din_ready;
  assign w_slot     = auto_inc ? r_wr_ptr : InMuxAdd;
  assign w_slot_oh  = NUM_SLOTS'(1) << w_slot;
  assign w_we       = w_xfer ? w_slot_oh : '0;
  assign w_mask_nxt = r_valid_mask | w_slot_oh;

  generate
    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
      onebysixteen_demux_loader_slot #(.SIZE(SIZE)) u_slot (
        .clk  (clk),
        .rst  (rst),
        .i_we (w_we[g]),
        .i_d  (din),
        .o_q  (w_y[g])
      );
    end
  endgenerate

  // Bank-tracking FSM. full follows the mask only, so a bank filled with a
  // mix of addressed and auto writes completes the same way. done can fire
  // only on the EMPTY/FILLING -> FULL edge, because FULL blocks transfers.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_state      <= S_EMPTY;
      r_valid_mask <= '0;
      r_wr_ptr     <= '0;
      r_full       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_xfer) begin
        r_valid_mask <= w_mask_nxt;
        if (auto_inc) r_wr_ptr <= r_wr_ptr + 4'd1;
        if (&w_mask_nxt) begin
          r_state <= S_FULL;
          r_full  <= 1'b1;
          r_done  <= 1'b1;
        end else begin
          r_state <= S_FILLING;
        end
      end
    end
  end

  assign valid_mask = r_valid_mask;
  assign wr_ptr     = r_wr_ptr;
  assign full       = r_full;
  assign done       = r_done;

  assign y0  = w_y[0];
  assign y1  = w_y[1];
  assign y2  = w_y[2];
  assign y3  = w_y[3];
  assign y4  = w_y[4];
  assign y5  = w_y[5];
  assign y6  = w_y[6];
  assign y7  = w_y[7];
  assign y8  = w_y[8];
  assign y9  = w_y[9];
  assign y10 = w_y[10];
  assign y11 = w_y[11];
  assign y12 = w_y[12];
  assign y13 = w_y[13];
  assign y14 = w_y[14];
  assign y15 = w_y[15];
endmodule

// File: tb/tb_onebysixteen_demux_loader.sv
module tb_onebysixteen_demux_loader;
  localparam int SIZE = 8;

  logic            clk = 1'b0;
  logic            rst, din_valid, auto_inc, clear;
  logic [SIZE-1:0] din;
  logic [3:0]      InMuxAdd;
  logic            din_ready, full, done;
  logic [15:0]     valid_mask;
  logic [3:0]      wr_ptr;
  logic [SIZE-1:0] yw [16];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  onebysixteen_demux_loader #(.SIZE(SIZE)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .InMuxAdd(InMuxAdd), .auto_inc(auto_inc), .clear(clear),
    .y0(yw[0]), .y1(yw[1]), .y2(yw[2]), .y3(yw[3]),
    .y4(yw[4]), .y5(yw[5]), .y6(yw[6]), .y7(yw[7]),
    .y8(yw[8]), .y9(yw[9]), .y10(yw[10]), .y11(yw[11]),
    .y12(yw[12]), .y13(yw[13]), .y14(yw[14]), .y15(yw[15]),
    .valid_mask(valid_mask), .wr_ptr(wr_ptr), .full(full), .done(done)
  );

  typedef struct {
    logic        rst, clr, vld, ai;
    logic [3:0]  addr;
    logic [7:0]  din;
    logic [15:0] e_mask;
    logic [3:0]  e_ptr;
    logic        e_full, e_done, e_rdy;
    int          e_idx;   // slot whose data is checked, -1 = none
    logic [7:0]  e_y;
  } vec_t;

  vec_t vt [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic c, input logic v, input logic a,
                       input logic [3:0] ad, input logic [7:0] d);
    rst = r; clear = c; din_valid = v; auto_inc = a; InMuxAdd = ad; din = d;
  endtask

  // Active edge, then sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic addv(input logic r, input logic c, input logic v, input logic a,
                      input logic [3:0] ad, input logic [7:0] d,
                      input logic [15:0] m, input logic [3:0] p,
                      input logic f, input logic dn, input logic rd,
                      input int idx, input logic [7:0] y);
    vec_t t;
    t.rst = r; t.clr = c; t.vld = v; t.ai = a; t.addr = ad; t.din = d;
    t.e_mask = m; t.e_ptr = p; t.e_full = f; t.e_done = dn; t.e_rdy = rd;
    t.e_idx = idx; t.e_y = y;
    vt.push_back(t);
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
  endtask

  int dcnt;
  logic [7:0] snap [16];

  initial begin
    drive(0, 0, 0, 0, 0, 0);

    // ---- table: reset, auto fill, overflow word, addressed writes ----
    addv(1,0,0,0,0,8'h00, 16'h0000, 4'd0, 0,0,1, 0, 8'h00);
    for (int i = 0; i < 16; i++)
      addv(0,0,1,1,0,8'(i),
           (i == 15) ? 16'hFFFF : 16'((32'd1 << (i+1)) - 1),
           4'((i+1) % 16), (i == 15), (i == 15), (i != 15), i, 8'(i));
    addv(0,0,1,1,0,8'hAA, 16'hFFFF, 4'd0, 1,0,0, 0, 8'h00);
    addv(0,0,0,1,0,8'h00, 16'hFFFF, 4'd0, 1,0,0, 15, 8'h0F);
    addv(1,0,0,0,0,8'h00, 16'h0000, 4'd0, 0,0,1, 15, 8'h00);
    addv(0,0,1,0,4'd3, 8'h05, 16'h0008, 4'd0, 0,0,1, 3, 8'h05);
    addv(0,0,1,0,4'd12,8'h07, 16'h1008, 4'd0, 0,0,1, 12, 8'h07);
    addv(0,0,1,0,4'd3, 8'h09, 16'h1008, 4'd0, 0,0,1, 3, 8'h09);
    addv(0,0,0,0,4'd0, 8'h00, 16'h1008, 4'd0, 0,0,1, 12, 8'h07);

    foreach (vt[k]) begin
      drive(vt[k].rst, vt[k].clr, vt[k].vld, vt[k].ai, vt[k].addr, vt[k].din);
      tick();
      chk($sformatf("v%0d.mask", k), 32'(valid_mask), 32'(vt[k].e_mask));
      chk($sformatf("v%0d.ptr",  k), 32'(wr_ptr),     32'(vt[k].e_ptr));
      chk($sformatf("v%0d.full", k), 32'(full),       32'(vt[k].e_full));
      chk($sformatf("v%0d.done", k), 32'(done),       32'(vt[k].e_done));
      chk($sformatf("v%0d.rdy",  k), 32'(din_ready),  32'(vt[k].e_rdy));
      if (vt[k].e_idx >= 0)
        chk($sformatf("v%0d.y%0d", k, vt[k].e_idx), 32'(yw[vt[k].e_idx]), 32'(vt[k].e_y));
    end

    // ---- clear priority ----
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 1, 1, 0, 8'(8'h10 + i));
      tick();
    end
    drive(0, 1, 1, 1, 0, 8'h55);
    #1;
    chk("clr.rdy_low", 32'(din_ready), 32'd0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("clr.mask", 32'(valid_mask), 32'h0);
    chk("clr.ptr",  32'(wr_ptr),     32'h0);
    chk("clr.y10",  32'(yw[10]),     32'h0);
    for (int i = 0; i < 10; i++)
      chk($sformatf("clr.y%0d", i), 32'(yw[i]), 32'(8'h10 + i));
    #1;
    chk("clr.rdy_after", 32'(din_ready), 32'd1);

    // ---- mixed mode: 4 auto, then addressed 4..15 ----
    dcnt = 0;
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, 1, 0, 8'(8'h20 + i));
      tick();
      dcnt += int'(done);
    end
    for (int s = 4; s < 16; s++) begin
      drive(0, 0, 1, 0, 4'(s), 8'(8'h40 + s));
      tick();
      dcnt += int'(done);
      chk($sformatf("mix.ptr%0d", s), 32'(wr_ptr), 32'd4);
    end
    chk("mix.full", 32'(full), 32'd1);
    chk("mix.done", 32'(done), 32'd1);
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      dcnt += int'(done);
    end
    chk("mix.done_count", 32'(dcnt), 32'd1);
    chk("mix.y2",  32'(yw[2]),  32'h22);
    chk("mix.y15", 32'(yw[15]), 32'h4F);

    // ---- auto resumes from held pointer and overwrites a valid slot ----
    do_reset();
    drive(0, 0, 1, 1, 0, 8'hA0); tick();
    drive(0, 0, 1, 0, 4'd1, 8'hB1); tick();
    drive(0, 0, 1, 1, 4'd9, 8'hC2); tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("res.y1",   32'(yw[1]),      32'hC2);
    chk("res.y9",   32'(yw[9]),      32'h00);
    chk("res.ptr",  32'(wr_ptr),     32'd2);
    chk("res.mask", 32'(valid_mask), 32'h0003);

    // ---- reset mid-fill ----
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(0, 0, 1, 1, 0, 8'(8'h60 + i));
      tick();
    end
    drive(1, 0, 1, 1, 0, 8'h77);
    tick();
    for (int i = 0; i < 16; i++)
      chk($sformatf("rmid.y%0d", i), 32'(yw[i]), 32'h0);
    chk("rmid.mask", 32'(valid_mask), 32'h0);
    chk("rmid.ptr",  32'(wr_ptr),     32'h0);
    chk("rmid.done", 32'(done),       32'h0);
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("rmid.rdy",  32'(din_ready),  32'd1);

    // ---- backpressure / idle, then full bank ignores input ----
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 1, 0, 8'(8'h80 + i));
      tick();
    end
    drive(0, 0, 0, 1, 4'd7, 8'hDD);
    for (int i = 0; i < 5; i++) tick();
    chk("idle.mask", 32'(valid_mask), 32'h0007);
    chk("idle.ptr",  32'(wr_ptr),     32'd3);
    chk("idle.y7",   32'(yw[7]),      32'h0);
    for (int i = 3; i < 16; i++) begin
      drive(0, 0, 1, 1, 0, 8'(8'h80 + i));
      tick();
    end
    chk("bp.full", 32'(full), 32'd1);
    chk("bp.done", 32'(done), 32'd1);
    for (int i = 0; i < 16; i++) snap[i] = 8'(8'h80 + i);
    dcnt = 0;
    drive(0, 0, 1, 1, 0, 8'hEE);
    for (int i = 0; i < 3; i++) begin
      tick();
      dcnt += int'(done);
      chk($sformatf("bp.rdy%0d", i), 32'(din_ready), 32'd0);
    end
    chk("bp.no_redone", 32'(dcnt), 32'd0);
    for (int i = 0; i < 16; i++)
      chk($sformatf("bp.y%0d", i), 32'(yw[i]), 32'(snap[i]));
    chk("bp.ptr", 32'(wr_ptr), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
